detector_sequencer: RTL and testbench
=====================================

DETECTOR_SEQUENCER -- requirements
Module: detector_sequencer

Interface
REQ-001 Parameter PAT_W, default 24, pattern length in bits.
REQ-002 Parameter CNT_W, default 8, hit counter width.
REQ-003 Parameter DRAIN_CYC, default 2, zero-bit flush cycles after the pattern.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  run request, accepted only when ready=1.
REQ-007 abort  in  1  cancel the current run.
REQ-008 pattern  in  PAT_W  bit stream, bit PAT_W-1 sent first, sampled on start acceptance.
REQ-009 ready  out  1  high only in IDLE.
REQ-010 busy  out  1  high in CLEAR, SHIFT, DRAIN, DONE.
REQ-011 done  out  1  one-cycle pulse marking normal run completion.
REQ-012 hit_count  out  CNT_W  detections counted in current/last run.
REQ-013 det_rst  out  1  reset to the sequence_detector.
REQ-014 det_ena  out  1  enable to the sequence_detector.
REQ-015 det_bit  out  1  serial test bit to the sequence_detector.
REQ-016 det_z  in  1  detection flag from the sequence_detector.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, SHIFT, DRAIN, DONE, encoded in one enum.
REQ-018 IDLE: start=1 and abort=0 SHALL latch pattern into shift register, clear hit_count, go to CLEAR.
REQ-019 CLEAR SHALL last exactly 1 cycle with det_rst=1, det_ena=0, then go to SHIFT.
REQ-020 SHIFT SHALL last exactly PAT_W cycles with det_ena=1, det_bit=shift register MSB, shifting left one bit per cycle, then go to DRAIN.
REQ-021 DRAIN SHALL last exactly DRAIN_CYC cycles with det_ena=1, det_bit=0, then go to DONE.
REQ-022 DONE SHALL last 1 cycle with done=1, det_ena=0, then go to IDLE.
REQ-023 Latency: start accepted at edge T gives CLEAR in cycle T+1, SHIFT in T+2..T+PAT_W+1, DRAIN next DRAIN_CYC cycles, done=1 in cycle T+PAT_W+DRAIN_CYC+2 (T+28 at defaults).
REQ-024 det_z SHALL be sampled every rising edge in SHIFT and DRAIN only; each sample of 1 increments hit_count by 1.
REQ-025 hit_count SHALL saturate at 2^CNT_W-1, never wrap.
REQ-026 hit_count SHALL hold its value in IDLE until the next accepted start.
REQ-027 abort=1 in any non-IDLE state SHALL go to IDLE next edge, no done pulse, hit_count held, det_ena=0 from that cycle.
REQ-028 start while busy=1 SHALL be ignored; pattern changes while busy SHALL not affect the run.
REQ-029 start=1 and abort=1 together in IDLE: abort wins, start ignored.
REQ-030 det_z high outside SHIFT/DRAIN SHALL be ignored.
REQ-031 det_bit SHALL be 0 whenever det_ena=0.

Reset
REQ-032 While rst=1: state=IDLE, hit_count=0, shift register=0, done=0, busy=0, ready=1, det_ena=0, det_bit=0, det_rst=1.
REQ-033 rst asserted mid-run SHALL apply REQ-032 immediately, asynchronously; no done pulse.
REQ-034 After rst release the block SHALL accept start on the first rising edge.

Structure
REQ-035 Package detector_sequencer_pkg SHALL hold the state enum typedef and defaults for PAT_W, CNT_W, DRAIN_CYC.
REQ-036 Saturating counter SHALL be sub-module sat_counter (clear, inc, saturate, CNT_W wide); FSM and shift register stay in detector_sequencer.

Verification (bench models det_z directly)
REQ-037 rst pulse mid-SHIFT -> all outputs per REQ-032 in same cycle; ready=1 after release, no done.
REQ-038 pattern=24'hA5A5A5, start at edge T -> det_rst=1 in T+1, det_bit sequence 1010_0101 x3 in T+2..T+25, 0,0 in T+26..T+27, done=1 only in T+28.
REQ-039 det_z held 1 throughout -> hit_count=26 at done; with CNT_W=4 -> hit_count=15, no wrap.
REQ-040 det_z pulsed in CLEAR, DONE, IDLE and 3 times in SHIFT -> hit_count=3.
REQ-041 abort in 10th SHIFT cycle -> IDLE/ready=1 next cycle, det_ena=0, no done, hit_count held.
REQ-042 start during SHIFT ignored (run completes at original T+28); start+abort together in IDLE -> stays IDLE.

Source files
------------

// File: rtl/detector_sequencer_pkg.sv
// Shared types and default parameters for the detector sequencer:
// the run-state enum and the default pattern, counter and drain sizes.
package detector_sequencer_pkg;

  localparam int PAT_W_DEF     = 24;
  localparam int CNT_W_DEF     = 8;
  localparam int DRAIN_CYC_DEF = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/detector_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1);

  // Count register: clear has priority, increments stop at the ceiling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/detector_sequencer.sv
// Drives a serial sequence detector through clear / shift / drain phases
// for one latched pattern and counts the detections it reports.
module detector_sequencer
  import detector_sequencer_pkg::*;
#(
  parameter int PAT_W     = PAT_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic             det_rst,
  output logic             det_ena,
  output logic             det_bit,
  input  logic             det_z
);

  localparam int CYC_MAX = (PAT_W > DRAIN_CYC) ? PAT_W : DRAIN_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam logic [CYC_W-1:0] CYC_ONE    = CYC_W'(1);
  localparam logic [CYC_W-1:0] SHIFT_LAST = CYC_W'(PAT_W - 1);
  localparam logic [CYC_W-1:0] DRAIN_LAST = CYC_W'(DRAIN_CYC - 1);

  state_t             state_r, state_s;
  logic [PAT_W-1:0]   shift_r, shift_s;
  logic [CYC_W-1:0]   cyc_r, cyc_s;
  logic               accept_s, inc_s;
  logic               ready_r, busy_r, done_r, det_rst_r, det_ena_r, det_bit_r;
  logic               ready_s, busy_s, done_s, det_rst_s, det_ena_s, det_bit_s;

  assign accept_s = (state_r == IDLE) && start && !abort;
  // A detection seen on the aborting edge is discarded so the count is frozen.
  assign inc_s    = ((state_r == SHIFT) || (state_r == DRAIN)) && det_z && !abort;

  // State, phase counter, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      shift_r   <= '0;
      cyc_r     <= '0;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      det_rst_r <= 1'b1;
      det_ena_r <= 1'b0;
      det_bit_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      cyc_r     <= cyc_s;
      ready_r   <= ready_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      det_rst_r <= det_rst_s;
      det_ena_r <= det_ena_s;
      det_bit_r <= det_bit_s;
    end
  end

  // Next state and phase length tracking.
  always_comb begin
    state_s = state_r;
    cyc_s   = cyc_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = CLEAR;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        if (abort) begin
          state_s = IDLE;
        end else begin
          state_s = SHIFT;
          cyc_s   = '0;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_s = IDLE;
        end else if (cyc_r == SHIFT_LAST) begin
          state_s = (DRAIN_CYC == 0) ? DONE : DRAIN;
          cyc_s   = '0;
        end else begin
          cyc_s = cyc_r + CYC_ONE;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_s = IDLE;
        end else if (cyc_r == DRAIN_LAST) begin
          state_s = DONE;
          cyc_s   = '0;
        end else begin
          cyc_s = cyc_r + CYC_ONE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Pattern is captured on acceptance and only moves while shifting.
  always_comb begin
    if (accept_s) begin
      shift_s = pattern;
    end else if (state_r == SHIFT) begin
      shift_s = {shift_r[PAT_W-2:0], 1'b0};
    end else begin
      shift_s = shift_r;
    end
  end

  // Outputs decoded from the upcoming state so they land in flops.
  always_comb begin
    ready_s   = 1'b0;
    busy_s    = 1'b1;
    done_s    = 1'b0;
    det_rst_s = 1'b0;
    det_ena_s = 1'b0;
    det_bit_s = 1'b0;
    case (state_s)
      IDLE: begin
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
      CLEAR:   det_rst_s = 1'b1;
      SHIFT: begin
        det_ena_s = 1'b1;
        det_bit_s = shift_s[PAT_W-1];
      end
      DRAIN:   det_ena_s = 1'b1;
      DONE:    done_s    = 1'b1;
      default: begin
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_hits (
    .clk   (clk),
    .rst   (rst),
    .clear (accept_s),
    .inc   (inc_s),
    .count (hit_count)
  );

  assign ready   = ready_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign det_rst = det_rst_r;
  assign det_ena = det_ena_r;
  assign det_bit = det_bit_r;

endmodule

// File: tb/tb_detector_sequencer.sv
// Directed bench for detector_sequencer: a run-offset model predicts every
// output each cycle, and literal checks pin the key timing and count values.
module tb_detector_sequencer;

  localparam int PW      = 24;
  localparam int DC      = 2;
  localparam int DONE_K  = PW + DC + 2;
  localparam int LAST_DZ = PW + DC + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] pattern = '0;
  logic          det_z = 1'b0;

  logic       ready8, busy8, done8, drst8, dena8, dbit8;
  logic [7:0] hit8;
  logic       ready4, busy4, done4, drst4, dena4, dbit4;
  logic [3:0] hit4;

  int n_vec = 0;
  int n_err = 0;

  detector_sequencer #(.PAT_W(PW), .CNT_W(8), .DRAIN_CYC(DC)) dut8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pattern),
    .ready(ready8), .busy(busy8), .done(done8), .hit_count(hit8),
    .det_rst(drst8), .det_ena(dena8), .det_bit(dbit8), .det_z(det_z));

  detector_sequencer #(.PAT_W(PW), .CNT_W(4), .DRAIN_CYC(DC)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pattern),
    .ready(ready4), .busy(busy4), .done(done4), .hit_count(hit4),
    .det_rst(drst4), .det_ena(dena4), .det_bit(dbit4), .det_z(det_z));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, got, exp);
    end
  endtask

  // Model: k_m is the number of edges since the run was accepted (0 = idle).
  int            k_m = 0;
  int            hits_m = 0;
  logic [PW-1:0] pat_m = '0;
  bit            post_rst_m = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k_m = 0;
      hits_m = 0;
      post_rst_m = 1'b1;
    end else begin
      post_rst_m = 1'b0;
      if (k_m != 0) begin
        if (abort) k_m = 0;
        else begin
          if (k_m >= 2 && k_m <= LAST_DZ && det_z) hits_m++;
          k_m = (k_m == DONE_K) ? 0 : k_m + 1;
        end
      end else if (start && !abort) begin
        k_m = 1;
        pat_m = pattern;
        hits_m = 0;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      begin
        int e_bit;
        int e_rst;
        e_bit = (k_m >= 2 && k_m <= PW + 1) ? int'(pat_m[PW-1-(k_m-2)]) : 0;
        e_rst = (rst || post_rst_m || k_m == 1) ? 1 : 0;
        chk("ready",   ready8, k_m == 0);
        chk("busy",    busy8,  k_m != 0);
        chk("done",    done8,  k_m == DONE_K);
        chk("det_rst", drst8,  e_rst);
        chk("det_ena", dena8,  k_m >= 2 && k_m <= LAST_DZ);
        chk("det_bit", dbit8,  e_bit);
        chk("hit8",    hit8,   (hits_m > 255) ? 255 : hits_m);
        chk("hit4",    hit4,   (hits_m > 15) ? 15 : hits_m);
        chk("ctl4",    {ready4, busy4, done4, drst4, dena4, dbit4},
                       {ready8, busy8, done8, drst8, dena8, dbit8});
      end
    end
  end

  // Drive a start at the current negedge; returns at the negedge of cycle k=1.
  task automatic launch(input logic [PW-1:0] pat);
    pattern = pat;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    logic [25:0] seq;
    logic [25:0] exp_seq;
    int          done_k;
    int          n_done;

    repeat (3) @(negedge clk);
    chk("rst_ready", ready8, 1);
    chk("rst_det_rst", drst8, 1);

    // A5A5A5 run, launched on the first edge after reset release,
    // with a pattern change and a stray start while shifting.
    rst = 1'b0;
    launch(24'hA5A5A5);
    seq = '0; done_k = 0; n_done = 0;
    for (int k = 1; k <= 29; k++) begin
      if (k == 1) chk("clear_det_rst", drst8, 1);
      if (k >= 2 && k <= 27) seq = {seq[24:0], dbit8};
      if (done8) begin done_k = k; n_done++; end
      if (k == 3) pattern = 24'h000000;
      if (k == 10) begin start = 1'b1; pattern = 24'hFFFFFF; end
      if (k == 11) start = 1'b0;
      @(negedge clk);
    end
    exp_seq = {24'hA5A5A5, 2'b00};
    chk("detbit_seq", int'(seq), int'(exp_seq));
    chk("done_offset", done_k, 28);
    chk("done_pulses", n_done, 1);

    // det_z held high everywhere: 26 counted, CNT_W=4 saturates at 15.
    det_z = 1'b1;
    launch(24'h123456);
    for (int k = 1; k <= 29; k++) begin
      if (k == 28) begin
        chk("sat_hit8", hit8, 26);
        chk("sat_hit4", hit4, 15);
      end
      @(negedge clk);
    end
    det_z = 1'b0;
    chk("hold_hit8", hit8, 26);

    // start and abort together in IDLE: abort wins.
    pattern = 24'h0F0F0F; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_ready", ready8, 1);

    // det_z pulses in IDLE, CLEAR, SHIFT x3 and DONE: only 3 count.
    det_z = 1'b1;
    @(negedge clk);
    det_z = 1'b0;
    launch(24'h0F0F0F);
    for (int k = 1; k <= 29; k++) begin
      det_z = (k == 1 || k == 5 || k == 9 || k == 20 || k == 28 || k == 29);
      if (k == 28) chk("pulse_hit", hit8, 3);
      @(negedge clk);
    end
    det_z = 1'b0;
    chk("pulse_hit_idle", hit8, 3);

    // Abort in the 10th shift cycle after 9 detections.
    launch(24'h3C3C3C);
    for (int k = 1; k <= 11; k++) begin
      det_z = (k >= 2 && k <= 10);
      if (k == 11) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    chk("abort_ready", ready8, 1);
    chk("abort_det_ena", dena8, 0);
    chk("abort_hit", hit8, 9);
    n_done = 0;
    for (int k = 0; k < 30; k++) begin
      if (done8) n_done++;
      @(negedge clk);
    end
    chk("abort_no_done", n_done, 0);

    // Asynchronous reset in the middle of SHIFT.
    launch(24'hFFFFFF);
    for (int k = 1; k <= 8; k++) begin
      det_z = (k >= 2 && k <= 6);
      if (k < 8) @(negedge clk);
    end
    det_z = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_ready", ready8, 1);
    chk("arst_busy", busy8, 0);
    chk("arst_det_ena", dena8, 0);
    chk("arst_det_bit", dbit8, 0);
    chk("arst_det_rst", drst8, 1);
    chk("arst_hit", hit8, 0);
    chk("arst_done", done8, 0);
    @(negedge clk);
    rst = 1'b0;
    launch(24'h5A5A5A);
    chk("post_rst_busy", busy8, 1);
    chk("post_rst_det_rst", drst8, 1);
    n_done = 0;
    for (int k = 1; k <= 30; k++) begin
      if (done8) n_done++;
      @(negedge clk);
    end
    chk("post_rst_done", n_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
